// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: address layout, command record and scheduler
// state encodings used by the request scheduler and the controller blocks.
package sdram_pkg;

  // Address field widths and bit offsets inside {bank, row, col}
  localparam int unsigned BANK_W   = 2;
  localparam int unsigned ROW_W    = 13;
  localparam int unsigned COL_W    = 9;
  localparam int unsigned COL_LSB  = 0;
  localparam int unsigned ROW_LSB  = COL_LSB + COL_W;
  localparam int unsigned BANK_LSB = ROW_LSB + ROW_W;
  localparam int unsigned ADDR_W   = BANK_LSB + BANK_W;

  // Scheduler states, one-hot
  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_ARB   = 5'b00010;
  localparam logic [4:0] ST_ISSUE = 5'b00100;
  localparam logic [4:0] ST_WAIT  = 5'b01000;
  localparam logic [4:0] ST_DONE  = 5'b10000;

  // Command presented to the controller port
  typedef struct packed {
    logic              wr;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } sdram_cmd_t;

  // Split a flat client address into a command record
  function automatic sdram_cmd_t make_cmd(input logic wr, input logic [ADDR_W-1:0] addr);
    sdram_cmd_t c;
    c.wr   = wr;
    c.bank = addr[BANK_LSB +: BANK_W];
    c.row  = addr[ROW_LSB +: ROW_W];
    c.col  = addr[COL_LSB +: COL_W];
    return c;
  endfunction

endpackage

// File: rtl/sdram_req_sched_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of vec_i
// scanning upward from ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  vec_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW:0] pos;

  // Walk N positions starting at the pointer; the first hit wins
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    pos      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      if (!any_o && vec_i[pos[PW-1:0]]) begin
        any_o                  = 1'b1;
        idx_o                  = pos[PW-1:0];
        onehot_o[pos[PW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_req_sched.sv
// Round-robin scheduler sharing the single SDRAM controller command port
// among NREQ clients, with a burst watchdog and init gating.
module sdram_req_sched
  import sdram_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AW       = 24,
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned WR_FIRST = 0
) (
  input  logic               sclk,
  input  logic               reset,
  input  logic               init_done,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    cli_done,
  output logic [NREQ-1:0]    cli_err,
  output logic               cmd_valid,
  output logic               cmd_wr,
  output logic [BANK_W-1:0]  cmd_bank,
  output logic [ROW_W-1:0]   cmd_row,
  output logic [COL_W-1:0]   cmd_col,
  input  logic               cmd_ack,
  input  logic               cmd_done,
  output logic               busy
);

  localparam int unsigned     PW     = $clog2(NREQ);
  localparam int unsigned     WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [PW-1:0]   LAST   = PW'(NREQ - 1);

  logic [4:0]      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   w_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] cli_done_q;
  logic [NREQ-1:0] cli_err_q;
  logic            cmd_valid_q;
  sdram_cmd_t      cmd_q;
  logic [WD_W-1:0] wdog_q;
  logic [WD_W-1:0] wd_next;
  logic            wd_hit;
  logic            ack_ok;

  logic [NREQ-1:0] wr_pend;
  logic [NREQ-1:0] scan_vec;
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [AW-1:0]   sel_addr;
  logic            sel_wr;
  sdram_cmd_t      sel_cmd;

  // Arbitration candidates: with write priority, pending writes hide reads
  always_comb begin
    wr_pend  = req & req_wr;
    scan_vec = req;
    if ((WR_FIRST != 0) && (wr_pend != '0)) begin
      scan_vec = wr_pend;
    end
  end

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .vec_i    (scan_vec),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Winner's op and address routed to the command register inputs
  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = req_addr[i*AW +: AW];
      end
    end
    sel_wr  = |(pick_oh & req_wr);
    sel_cmd = make_cmd(sel_wr, sel_addr[ADDR_W-1:0]);
  end

  // Saturating watchdog; a hit means this WAIT cycle is the last allowed one
  always_comb begin
    wd_next = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
    wd_hit  = (wd_next == WD_MAX);
    ack_ok  = cmd_ack && cmd_valid_q;
  end

  // Next-state logic; losing init overrides every state
  always_comb begin
    state_d = state_q;
    if (!init_done) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ARB;
        ST_ARB:   if (pick_any) state_d = ST_ISSUE;
        ST_ISSUE: if (ack_ok) state_d = ST_WAIT;
        ST_WAIT:  if (cmd_done || wd_hit) state_d = ST_DONE;
        ST_DONE:  state_d = ST_ARB;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, command, watchdog and completion-pulse registers
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      w_q         <= '0;
      gnt_q       <= '0;
      cli_done_q  <= '0;
      cli_err_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      wdog_q      <= '0;
    end else begin
      cli_done_q <= '0;
      cli_err_q  <= '0;
      if (!init_done) begin
        gnt_q       <= '0;
        cmd_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ARB: begin
            if (pick_any) begin
              gnt_q <= pick_oh;
              w_q   <= pick_idx;
              cmd_q <= sel_cmd;
            end
          end
          ST_ISSUE: begin
            if (ack_ok) begin
              cmd_valid_q <= 1'b0;
              wdog_q      <= '0;
            end else begin
              cmd_valid_q <= 1'b1;
            end
          end
          ST_WAIT: begin
            wdog_q <= wd_next;
            // cmd_done in the final watchdog cycle still counts as success
            if (cmd_done || wd_hit) begin
              cli_done_q <= gnt_q;
              cli_err_q  <= cmd_done ? '0 : gnt_q;
            end
          end
          ST_DONE: begin
            gnt_q    <= '0;
            rr_ptr_q <= (w_q == LAST) ? '0 : w_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign gnt       = gnt_q;
  assign cli_done  = cli_done_q;
  assign cli_err   = cli_err_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_q.wr;
  assign cmd_bank  = cmd_q.bank;
  assign cmd_row   = cmd_q.row;
  assign cmd_col   = cmd_q.col;
  assign busy      = |(state_q & (ST_ISSUE | ST_WAIT | ST_DONE));

endmodule

// File: doc/sdram_req_sched.md
Name: sdram_req_sched

Overview:
- Round-robin scheduler that shares the single SDRAM controller port among NREQ client requesters.
- Each client posts one write or read burst request (bank/row/col). The scheduler picks a winner, presents a command to the controller (wr_trig/rd_trig style handshake), and holds the grant until the controller reports burst completion.
- Sits between the user-side clients and sdram_top. Blocks all issue until SDRAM init completes.
- Watchdog aborts a hung burst.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 24, per-request address width: {bank[1:0], row[12:0], col[8:0]}.
- TIMEOUT, 1023, max cycles from cmd_ack to cmd_done before abort.
- WR_FIRST, 0, 1 = pending writes beat pending reads before round-robin order is applied.

Ports:
- sclk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- init_done  in  1  SDRAM initialisation finished (flag_init_end)
- req  in  NREQ  per-client request, level, held until cli_done
- req_wr  in  NREQ  per-client op: 1 = write, 0 = read; stable while req high
- req_addr  in  NREQ*AW  per-client address, client i at [i*AW +: AW]
- gnt  out  NREQ  one-hot grant, held for whole burst
- cli_done  out  NREQ  one-cycle completion pulse to granted client
- cli_err  out  NREQ  one-cycle pulse coincident with cli_done on timeout abort
- cmd_valid  out  1  command presented to controller
- cmd_wr  out  1  1 = write burst, 0 = read burst
- cmd_bank  out  2  bank
- cmd_row  out  13  row
- cmd_col  out  9  column
- cmd_ack  in  1  controller accepted command (one-cycle pulse)
- cmd_done  in  1  controller burst end (flag_wr_end/flag_rd_end), one-cycle pulse
- busy  out  1  high in any state except IDLE/ARB

Behaviour:
- Reset values: all outputs 0; state = IDLE; rr_ptr = 0; watchdog = 0.
- States (one-hot): IDLE, ARB, ISSUE, WAIT, DONE.
- IDLE: go to ARB when init_done = 1.
- ARB:
  - Stay in ARB if req == 0.
  - Otherwise select winner w: first set bit of req scanning from rr_ptr upward with wrap-around modulo NREQ.
  - If WR_FIRST = 1 and any (req & req_wr) != 0, the scan is restricted to req & req_wr.
  - Register w, latch its req_wr/req_addr into command registers, set gnt[w], go to ISSUE. Total: 1 cycle in ARB.
- ISSUE:
  - cmd_valid = 1 with latched fields.
  - On cmd_ack: drop cmd_valid the next cycle, clear watchdog, go to WAIT.
  - cmd_valid held indefinitely until ack; no timeout in ISSUE.
- WAIT:
  - Watchdog increments each cycle.
  - On cmd_done: go to DONE.
  - If watchdog reaches TIMEOUT without cmd_done: go to DONE with err flag set.
  - cmd_done and timeout in the same cycle: treated as success, no error.
- DONE (1 cycle):
  - Pulse cli_done[w] (and cli_err[w] if err).
  - Clear gnt.
  - rr_ptr = (w+1) mod NREQ.
  - Return to ARB.
- A client may reassert req in the cycle after cli_done. The earliest next grant to the same client is 2 cycles after DONE, provided no other client is pending.
- Latency, idle bus: req rise at cycle 0 -> gnt and command registers at cycle 1 -> cmd_valid at cycle 2 (ISSUE).
- Request withdrawal: dropping req while granted is ignored; the burst completes and cli_done still pulses.
- cmd_ack or cmd_done outside the expected state: ignored.
- init_done falling at any point: force IDLE next cycle, deassert gnt/cmd_valid, no cli_done pulse. rr_ptr is kept.
- Async reset mid-burst: all outputs 0 immediately; state IDLE.
- Fairness: any continuously requesting client is granted within NREQ grants (WR_FIRST = 0). With WR_FIRST = 1, reads may starve; this is documented, not fixed.
- Widths: rr_ptr and w are $clog2(NREQ) bits; watchdog is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Package sdram_pkg holds:
  - state encodings;
  - address field widths and offsets (BANK_W = 2, ROW_W = 13, COL_W = 9);
  - command field slice constants shared with sdram_top/sdram_write/sdram_read.
- One sub-module, rr_pick: combinational masked round-robin priority encoder.
  - Inputs: vector and pointer.
  - Outputs: one-hot winner and index.
  - Reused later for a bank scheduler.

Test Plan:
1. init_done = 0 with req = 4'b0001 -> no gnt, cmd_valid stays 0. Raise init_done -> gnt = 0001 two cycles later; cmd_valid one cycle after gnt with addr fields matching client 0.
2. req = 4'b1111 held, each burst acked and done after 5 cycles -> grant order 0,1,2,3,0; each cli_done is a single cycle; gnt is never multi-hot.
3. WR_FIRST = 1, req = 4'b0011, req_wr = 4'b0010, rr_ptr = 0 -> client 1 granted first, cmd_wr = 1; then client 0, cmd_wr = 0.
4. TIMEOUT = 15, ack given, cmd_done withheld -> cli_done and cli_err pulse together 15 cycles after ack for that client; the next requester is then granted.
5. cmd_done and timeout in the same cycle -> cli_done = 1, cli_err = 0.
6. Assert reset low during WAIT -> gnt, cmd_valid, busy = 0 the same cycle. Release reset with init_done = 1 -> normal arbitration from rr_ptr = 0.
